// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the RV32I pipeline: combinational ALU, branch decision and byte-addressable data memory.
// Optional build macro MISALIGN_CHECK_EN adds a misalign output and suppresses misaligned accesses.
module exec_mem_unit #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    // ALU
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_o,
    // branch control
    input  logic [2:0]  br_type,
    input  logic [6:0]  op_code,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        br_en,
    // data memory
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        mem_wr,
    input  logic        mem_rd,
    input  logic [2:0]  mask,
`ifdef MISALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic [31:0] dmem_o
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        alu_o = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_o = a + b;
            ALU_SUB:  alu_o = a - b;
            ALU_SLL:  alu_o = a << shamt;
            ALU_SLT:  alu_o = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: alu_o = {31'd0, a < b};
            ALU_XOR:  alu_o = a ^ b;
            ALU_SRL:  alu_o = a >> shamt;
            ALU_SRA:  alu_o = $unsigned($signed(a) >>> shamt);
            ALU_OR:   alu_o = a | b;
            ALU_AND:  alu_o = a & b;
            ALU_PASS: alu_o = b;
            default:  alu_o = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch decision (uses register-file operands, not forwarded ones)
    // ------------------------------------------------------------------
    logic cmp_eq;
    logic cmp_lt;
    logic cmp_ltu;

    assign cmp_eq  = (rs1_data == rs2_data);
    assign cmp_lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign cmp_ltu = (rs1_data < rs2_data);

    always_comb begin
        br_en = 1'b0;
        if (op_code == OPC_JAL || op_code == OPC_JALR) begin
            br_en = 1'b1;
        end else if (op_code == OPC_BRANCH) begin
            case (br_type)
                3'b000:  br_en = cmp_eq;
                3'b001:  br_en = !cmp_eq;
                3'b100:  br_en = cmp_lt;
                3'b101:  br_en = !cmp_lt;
                3'b110:  br_en = cmp_ltu;
                3'b111:  br_en = !cmp_ltu;
                default: br_en = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          access_bad;
    logic          unused_addr_hi;

    // Upper address bits are dropped so the array aliases modulo 4*DEPTH_WORDS.
    assign word_idx       = addr[AW+1:2];
    assign lane           = addr[1:0];
    assign unused_addr_hi = ^addr[31:AW+2];

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (mem_wr || mem_rd) begin
            if (mask[1:0] == 2'b01 && lane[0]) begin
                misalign = 1'b1;
            end else if (mask == MASK_W && lane != 2'b00) begin
                misalign = 1'b1;
            end
        end
    end
    assign access_bad = misalign;
`else
    assign access_bad = 1'b0;
`endif

    // Reset clears the whole array and wins over a simultaneous store.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (mem_wr && !access_bad) begin
            case (mask)
                MASK_B: begin
                    case (lane)
                        2'd0: mem[word_idx][7:0]   <= wr_data[7:0];
                        2'd1: mem[word_idx][15:8]  <= wr_data[7:0];
                        2'd2: mem[word_idx][23:16] <= wr_data[7:0];
                        2'd3: mem[word_idx][31:24] <= wr_data[7:0];
                        default: ;
                    endcase
                end
                MASK_H: begin
                    if (lane[1]) begin
                        mem[word_idx][31:16] <= wr_data[15:0];
                    end else begin
                        mem[word_idx][15:0] <= wr_data[15:0];
                    end
                end
                MASK_W:  mem[word_idx] <= wr_data;
                default: ;
            endcase
        end
    end

    // Combinational read returns pre-edge contents during a same-cycle store.
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_word = mem[word_idx];

    always_comb begin
        rd_byte = 8'd0;
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = 8'd0;
        endcase
    end

    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        dmem_o = 32'd0;
        if (mem_rd && !access_bad) begin
            case (mask)
                MASK_B:  dmem_o = {{24{rd_byte[7]}}, rd_byte};
                MASK_H:  dmem_o = {{16{rd_half[15]}}, rd_half};
                MASK_W:  dmem_o = rd_word;
                MASK_BU: dmem_o = {24'd0, rd_byte};
                MASK_HU: dmem_o = {16'd0, rd_half};
                default: dmem_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: ALU, branch decision, memory load/store, wrap and reset.
// Define MISALIGN_CHECK_EN to exercise the misalign port.
module tb_exec_mem_unit;

    localparam int DEPTH_WORDS = 256;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [31:0] alu_o;
    logic [2:0]  br_type;
    logic [6:0]  op_code;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        br_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [2:0]  mask;
    logic [31:0] dmem_o;
`ifdef MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_val;

    exec_mem_unit #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .alu_o    (alu_o),
        .br_type  (br_type),
        .op_code  (op_code),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .br_en    (br_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mask     (mask),
`ifdef MISALIGN_CHECK_EN
        .misalign (misalign),
`endif
        .dmem_o   (dmem_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: expected value is queued, then popped against the observation
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // driver tasks
    task automatic run_alu(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] op);
        a = av; b = bv; alu_op = op;
        #1;
    endtask

    task automatic run_br(input logic [6:0] opc, input logic [2:0] bt,
                          input logic [31:0] r1, input logic [31:0] r2);
        op_code = opc; br_type = bt; rs1_data = r1; rs2_data = r2;
        #1;
    endtask

    task automatic store(input logic [31:0] ad, input logic [31:0] d, input logic [2:0] m);
        @(negedge clk);
        addr = ad; wr_data = d; mask = m; mem_wr = 1'b1; mem_rd = 1'b0;
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    task automatic load(input logic [31:0] ad, input logic [2:0] m, output logic [31:0] d);
        @(negedge clk);
        addr = ad; mask = m; mem_rd = 1'b1; mem_wr = 1'b0;
        #1;
        d = dmem_o;
    endtask

    initial begin
        rst = 1'b1;
        a = '0; b = '0; alu_op = '0;
        br_type = '0; op_code = '0; rs1_data = '0; rs2_data = '0;
        addr = '0; wr_data = '0; mem_wr = 1'b0; mem_rd = 1'b0; mask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        load(32'h0, 3'b010, rd_val);
        check("reset_lw0", rd_val, 32'h0);

        // ALU
        run_alu(32'hFFFF_FFFF, 32'd1, 4'd0);  check("alu_add_wrap", alu_o, 32'h0000_0000);
        run_alu(32'hFFFF_FFFF, 32'd1, 4'd1);  check("alu_sub",      alu_o, 32'hFFFF_FFFE);
        run_alu(32'hFFFF_FFFF, 32'd1, 4'd3);  check("alu_slt",      alu_o, 32'd1);
        run_alu(32'hFFFF_FFFF, 32'd1, 4'd4);  check("alu_sltu",     alu_o, 32'd0);
        run_alu(32'h8000_0000, 32'd4, 4'd7);  check("alu_sra",      alu_o, 32'hF800_0000);
        run_alu(32'h8000_0000, 32'd4, 4'd6);  check("alu_srl",      alu_o, 32'h0800_0000);
        run_alu(32'd1, 32'h0000_003F, 4'd2);  check("alu_sll_b4_0", alu_o, 32'h8000_0000);
        run_alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'd5); check("alu_xor", alu_o, 32'hFF00_12CB);
        run_alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'd8); check("alu_or",  alu_o, 32'hFFF0_12FF);
        run_alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'd9); check("alu_and", alu_o, 32'h00F0_0034);
        run_alu(32'h1234_5678, 32'hABCD_E000, 4'd10); check("alu_pass_b", alu_o, 32'hABCD_E000);
        run_alu(32'hFFFF_FFFF, 32'd1, 4'd12); check("alu_op12",     alu_o, 32'd0);

        // branch decision
        run_br(7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1); check("br_blt",  {31'd0, br_en}, 32'd1);
        run_br(7'b1100011, 3'b110, 32'hFFFF_FFFF, 32'd1); check("br_bltu", {31'd0, br_en}, 32'd0);
        run_br(7'b1100011, 3'b101, 32'hFFFF_FFFF, 32'd1); check("br_bge",  {31'd0, br_en}, 32'd0);
        run_br(7'b1100011, 3'b111, 32'hFFFF_FFFF, 32'd1); check("br_bgeu", {31'd0, br_en}, 32'd1);
        run_br(7'b1100011, 3'b000, 32'h55, 32'h55);       check("br_beq",  {31'd0, br_en}, 32'd1);
        run_br(7'b1100011, 3'b001, 32'h55, 32'h55);       check("br_bne",  {31'd0, br_en}, 32'd0);
        run_br(7'b1100011, 3'b010, 32'h55, 32'h55);       check("br_rsvd", {31'd0, br_en}, 32'd0);
        run_br(7'b1101111, 3'b001, 32'h55, 32'h55);       check("br_jal",  {31'd0, br_en}, 32'd1);
        run_br(7'b1100111, 3'b000, 32'h1, 32'h2);         check("br_jalr", {31'd0, br_en}, 32'd1);
        run_br(7'b0110011, 3'b000, 32'h55, 32'h55);       check("br_rtype",{31'd0, br_en}, 32'd0);

        // store / sized loads
        store(32'h10, 32'h8BAD_F00D, 3'b010);
        load(32'h13, 3'b000, rd_val); check("lb_0x13",  rd_val, 32'hFFFF_FF8B);
        load(32'h13, 3'b100, rd_val); check("lbu_0x13", rd_val, 32'h0000_008B);
        load(32'h12, 3'b001, rd_val); check("lh_0x12",  rd_val, 32'hFFFF_8BAD);
        load(32'h10, 3'b101, rd_val); check("lhu_0x10", rd_val, 32'h0000_F00D);
        load(32'h10, 3'b011, rd_val); check("ld_rsvd",  rd_val, 32'h0);

        // byte merge
        store(32'h20, 32'h0, 3'b010);
        store(32'h21, 32'h1234_5678, 3'b000);
        store(32'h22, 32'hAAAA_5555, 3'b001);
        store(32'h20, 32'hFFFF_FFFF, 3'b011);
        load(32'h20, 3'b010, rd_val); check("merge_lw", rd_val, 32'h5555_7800);

        // read during write: old data before the edge, new data after
        @(negedge clk);
        addr = 32'h10; wr_data = 32'h0BAD_CAFE; mask = 3'b010; mem_wr = 1'b1; mem_rd = 1'b1;
        #1;
        check("rdw_old", dmem_o, 32'h8BAD_F00D);
        @(negedge clk);
        mem_wr = 1'b0;
        #1;
        check("rdw_new", dmem_o, 32'h0BAD_CAFE);

        // address wrap
        store(32'h0, 32'h11, 3'b010);
        store(32'h0 + 4 * DEPTH_WORDS, 32'h22, 3'b010);
        load(32'h0, 3'b010, rd_val); check("wrap_lw0", rd_val, 32'h22);

        // reset with a concurrent store
        @(negedge clk);
        rst = 1'b1; addr = 32'h0; wr_data = 32'h55; mask = 3'b010; mem_wr = 1'b1; mem_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_wr = 1'b0;
        load(32'h0, 3'b010, rd_val);  check("rst_lw0",  rd_val, 32'h0);
        load(32'h10, 3'b010, rd_val); check("rst_lw10", rd_val, 32'h0);

        store(32'h4, 32'h7777_1234, 3'b010);
        @(negedge clk);
        addr = 32'h4; mask = 3'b010; mem_rd = 1'b0;
        #1;
        check("rd_off", dmem_o, 32'h0);

`ifdef MISALIGN_CHECK_EN
        store(32'h0, 32'h1234_5678, 3'b010);
        @(negedge clk);
        addr = 32'h2; wr_data = 32'hDEAD_BEEF; mask = 3'b010; mem_wr = 1'b1; mem_rd = 1'b0;
        #1;
        check("mis_sw_flag", {31'd0, misalign}, 32'd1);
        @(negedge clk);
        mem_wr = 1'b0;
        load(32'h0, 3'b010, rd_val); check("mis_sw_nowrite", rd_val, 32'h1234_5678);
        check("mis_lw_aligned_flag", {31'd0, misalign}, 32'd0);
        load(32'h1, 3'b001, rd_val); check("mis_lh_data", rd_val, 32'h0);
        check("mis_lh_flag", {31'd0, misalign}, 32'd1);
`else
        // misaligned word store ignores addr[1:0]
        store(32'h6, 32'hCAFE_BABE, 3'b010);
        load(32'h4, 3'b010, rd_val); check("sw_lowbits_ignored", rd_val, 32'hCAFE_BABE);
        load(32'h5, 3'b001, rd_val); check("lh_odd_ignored", rd_val, 32'hFFFF_BABE);
`endif

        @(negedge clk);
        mem_rd = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
- Combined execute/memory datapath slice of the 5-stage RV32I pipeline.
- Three parts:
  - Combinational 32-bit ALU.
  - Branch-decision logic, which produces the PC-select signal in the E stage.
  - Byte-addressable data memory, accessed in the M stage.
- The three parts share only clock and reset; each side's inputs come from the E or M pipeline registers.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit memory words (power of 2).
- AW, $clog2(DEPTH_WORDS), word-index width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a  in  32  ALU operand A.
- b  in  32  ALU operand B.
- alu_op  in  4  ALU operation select.
- alu_o  out  32  ALU result.
- br_type  in  3  branch condition (instruction funct3).
- op_code  in  7  instruction opcode of the E-stage instruction.
- rs1_data  in  32  branch compare operand 1.
- rs2_data  in  32  branch compare operand 2.
- br_en  out  1  1 = redirect PC to alu_o.
- addr  in  32  memory byte address.
- wr_data  in  32  store data (low bytes used for SB/SH).
- mem_wr  in  1  store enable.
- mem_rd  in  1  load enable.
- mask  in  3  access size/sign (instruction funct3).
- dmem_o  out  32  load data, extended to 32 bits.

Behaviour:
- ALU, purely combinational. alu_op encodings:
  - 0 ADD, 1 SUB.
  - 2 SLL, 3 SLT (signed), 4 SLTU.
  - 5 XOR, 6 SRL, 7 SRA.
  - 8 OR, 9 AND, 10 PASS_B (LUI).
  - 11-15 produce 0.
  - Shift amount is b[4:0].
  - ADD/SUB wrap modulo 2^32.
  - SLT/SLTU output 0 or 1.
- Branch control, purely combinational:
  - op_code 1101111 (JAL) or 1100111 (JALR): br_en=1 unconditionally.
  - op_code 1100011 (branch): br_type 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Codes 010/011 give br_en=0.
  - Any other opcode: br_en=0.
  - Compares rs1_data vs rs2_data (not forwarded values).
- Data memory:
  - DEPTH_WORDS x 32 array. Word index = addr[AW+1:2]; upper address bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Writes are synchronous at posedge when mem_wr=1 and rst=0:
  - mask 000 SB: byte lane addr[1:0] <= wr_data[7:0].
  - mask 001 SH: halfword lane addr[1] <= wr_data[15:0].
  - mask 010 SW: full word <= wr_data; addr[1:0] ignored.
  - Other mask values: no write.
- Reads are combinational (same cycle):
  - When mem_rd=1:
    - 000 LB: sign-extended byte at addr[1:0].
    - 001 LH: sign-extended halfword at addr[1].
    - 010 LW: full word.
    - 100 LBU: zero-extended byte.
    - 101 LHU: zero-extended halfword.
    - Other mask values: 0.
  - When mem_rd=0: dmem_o=0.
- Read-during-write to the same address in the same cycle: dmem_o shows old contents; new data is visible after the edge.
- Reset: at posedge with rst=1, every memory word is cleared to 0.
  - Reset has priority over a simultaneous write.
  - alu_o and br_en are unaffected by reset.
  - dmem_o reads 0 after reset.
- Mid-operation reset discards all stored data.
- mem_wr and mem_rd both high: write occurs at the edge; read returns pre-edge data.

Optional Feature:
- Macro MISALIGN_CHECK_EN adds output port misalign (1 bit, combinational).
- misalign=1 when (mem_wr|mem_rd) and either:
  - halfword access with addr[0]=1, or
  - word access with addr[1:0]!=0.
- While misalign=1: stores are suppressed and dmem_o=0.
- Without the macro: no port; misaligned bits are silently ignored as described above.

Test Plan:
- ALU: a=0xFFFFFFFF, b=1. ADD -> 0x00000000; SLT -> 1; SLTU -> 0; SRA with b=4 on a=0x80000000 -> 0xF8000000; op 12 -> 0.
- Branch: op_code 1100011, br_type 100, rs1=0xFFFFFFFF, rs2=1 -> br_en=1. br_type 110 with the same operands -> br_en=0. op_code 1101111 with any operands -> br_en=1. op_code 0110011 -> br_en=0.
- Store/load: SW 0x8badf00d @0x10, then LB @0x13 -> 0xFFFFFF8B; LBU @0x13 -> 0x0000008B; LH @0x12 -> 0xFFFF8BAD; LHU @0x10 -> 0x0000F00D.
- Byte merge: SW 0 @0x20, SB 0x12345678 @0x21, SH 0xAAAA5555 @0x22, then LW @0x20 -> 0x55557800.
- Wrap and reset: SW 0x11 @0x0 and SW 0x22 @(4*DEPTH_WORDS) -> LW @0x0 returns 0x22. Assert rst one cycle with mem_wr=1 -> LW @0x0 returns 0. mem_rd=0 -> dmem_o=0.
- MISALIGN_CHECK_EN build: SW @0x2 -> misalign=1, memory unchanged. LH @0x1 -> dmem_o=0.
